// File: rtl/traffic_light_controller.sv
// traffic_light_controller
// Moore sequencer for a main/side road junction with a pedestrian request.
// The divider's slow square wave is sampled as data and each rising edge
// becomes a one-cycle tick; every phase length is counted in ticks.
// Lamps and walk are a pure decode of registered state, so they never glitch
// and both roads can never show non-red at the same time.

module traffic_light_controller #(
  parameter int unsigned MAIN_GREEN_MIN = 8,
  parameter int unsigned YELLOW_T       = 3,
  parameter int unsigned ALLRED_T       = 1,
  parameter int unsigned SIDE_GREEN_T   = 5,
  parameter int unsigned TW             = 8
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       slow_clk,
  input  logic       side_car,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] state
);

  // Phase encodings; the debug port exposes these codes directly.
  typedef enum logic [2:0] {
    ST_ALL_RED_B   = 3'd0,
    ST_MAIN_GREEN  = 3'd1,
    ST_MAIN_YELLOW = 3'd2,
    ST_ALL_RED_A   = 3'd3,
    ST_SIDE_GREEN  = 3'd4,
    ST_SIDE_YELLOW = 3'd5
  } state_e;

  // Lamp patterns, {R,Y,G}.
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  // Last timer value of each phase (duration minus one), as TW-bit unsigned.
  localparam logic [TW-1:0] MG_LAST = TW'(MAIN_GREEN_MIN - 1);
  localparam logic [TW-1:0] Y_LAST  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] AR_LAST = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] SG_LAST = TW'(SIDE_GREEN_T - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  // The state register is kept as a plain vector so that the illegal codes
  // 6 and 7 remain representable and are explicitly recovered from.
  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          car_pend_q;
  logic          car_pend_d;
  logic          ped_pend_q;
  logic          ped_pend_d;
  logic          walk_serve_q;
  logic          walk_serve_d;
  logic          slow_q;
  logic          tick_s;
  logic          state_change_s;
  logic          enter_side_green_s;
  logic          main_sat_s;

  // A rising edge of the divider output, seen as data in the clk_in domain.
  assign tick_s = slow_clk & ~slow_q;

  // Register every piece of state; synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q      <= ST_ALL_RED_B;
      timer_q      <= '0;
      car_pend_q   <= 1'b0;
      ped_pend_q   <= 1'b0;
      walk_serve_q <= 1'b0;
      slow_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      car_pend_q   <= car_pend_d;
      ped_pend_q   <= ped_pend_d;
      walk_serve_q <= walk_serve_d;
      slow_q       <= slow_clk;
    end
  end

  // Next-state selection: fixed phases leave on the tick that completes them,
  // main green leaves only once saturated and a request is pending.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ALL_RED_B: begin
        if (tick_s && (timer_q == AR_LAST)) begin
          state_d = ST_MAIN_GREEN;
        end else begin
          state_d = ST_ALL_RED_B;
        end
      end
      ST_MAIN_GREEN: begin
        if (tick_s && (timer_q == MG_LAST) && (car_pend_q || ped_pend_q)) begin
          state_d = ST_MAIN_YELLOW;
        end else begin
          state_d = ST_MAIN_GREEN;
        end
      end
      ST_MAIN_YELLOW: begin
        if (tick_s && (timer_q == Y_LAST)) begin
          state_d = ST_ALL_RED_A;
        end else begin
          state_d = ST_MAIN_YELLOW;
        end
      end
      ST_ALL_RED_A: begin
        if (tick_s && (timer_q == AR_LAST)) begin
          state_d = ST_SIDE_GREEN;
        end else begin
          state_d = ST_ALL_RED_A;
        end
      end
      ST_SIDE_GREEN: begin
        if (tick_s && (timer_q == SG_LAST)) begin
          state_d = ST_SIDE_YELLOW;
        end else begin
          state_d = ST_SIDE_GREEN;
        end
      end
      ST_SIDE_YELLOW: begin
        if (tick_s && (timer_q == Y_LAST)) begin
          state_d = ST_ALL_RED_B;
        end else begin
          state_d = ST_SIDE_YELLOW;
        end
      end
      default: begin
        state_d = ST_ALL_RED_B;
      end
    endcase
  end

  assign state_change_s     = (state_d != state_q);
  assign enter_side_green_s = (state_d == ST_SIDE_GREEN) && (state_q != ST_SIDE_GREEN);
  assign main_sat_s         = (state_q == ST_MAIN_GREEN) && (timer_q == MG_LAST);

  // Phase timer: cleared on any state change, counts ticks otherwise and
  // saturates in main green so a long quiet green can never wrap.
  always_comb begin
    timer_d = timer_q;
    if (state_change_s) begin
      timer_d = '0;
    end else if (tick_s && !main_sat_s) begin
      timer_d = timer_q + TIMER_ONE;
    end else begin
      timer_d = timer_q;
    end
  end

  // Request latches: set by any asserted cycle, cleared when side green is
  // entered; the clear takes priority so a simultaneous request counts as served.
  always_comb begin
    car_pend_d   = car_pend_q | side_car;
    ped_pend_d   = ped_pend_q | ped_req;
    walk_serve_d = walk_serve_q;
    if (enter_side_green_s) begin
      car_pend_d   = 1'b0;
      ped_pend_d   = 1'b0;
      walk_serve_d = ped_pend_q;
    end else begin
      walk_serve_d = walk_serve_q;
    end
  end

  // Lamp and walk decode from the state register; illegal codes show all-red.
  always_comb begin
    main_light = LAMP_RED;
    side_light = LAMP_RED;
    walk       = 1'b0;
    case (state_q)
      ST_ALL_RED_B: begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
      end
      ST_MAIN_GREEN: begin
        main_light = LAMP_GREEN;
        side_light = LAMP_RED;
      end
      ST_MAIN_YELLOW: begin
        main_light = LAMP_YELLOW;
        side_light = LAMP_RED;
      end
      ST_ALL_RED_A: begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
      end
      ST_SIDE_GREEN: begin
        main_light = LAMP_RED;
        side_light = LAMP_GREEN;
        walk       = walk_serve_q;
      end
      ST_SIDE_YELLOW: begin
        main_light = LAMP_RED;
        side_light = LAMP_YELLOW;
      end
      default: begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
        walk       = 1'b0;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller with default parameters.
// slow_clk runs at 4 clk_in cycles per period (2 high, 2 low): one tick per 4 cycles.

module tb_traffic_light_controller;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       slow_clk = 1'b1;
  logic       side_car = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;
  int phase_cur = 0;
  bit auto_slow = 1'b1;

  traffic_light_controller dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .slow_clk   (slow_clk),
    .side_car   (side_car),
    .ped_req    (ped_req),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .state      (state)
  );

  always #5 clk_in = ~clk_in;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected lamps per state code, straight from the state table.
  function automatic logic [5:0] lamps_of(input logic [2:0] st);
    case (st)
      3'd1:    lamps_of = {3'b001, 3'b100};
      3'd2:    lamps_of = {3'b010, 3'b100};
      3'd4:    lamps_of = {3'b100, 3'b001};
      3'd5:    lamps_of = {3'b100, 3'b010};
      default: lamps_of = {3'b100, 3'b100};
    endcase
  endfunction

  // One clk_in edge, then drive slow_clk for the following cycle.
  task automatic cyc();
    @(posedge clk_in);
    #1;
    if (auto_slow) begin
      phase_cur = (phase_cur + 1) % 4;
      slow_clk  = (phase_cur < 2);
    end
  endtask

  // Advance until the edge that ends a tick cycle (phase 0) has passed.
  task automatic tick();
    int was;
    for (int k = 0; k < 8; k++) begin
      was = phase_cur;
      cyc();
      if (was == 0) break;
    end
  endtask

  // Expect state st (with lamps and walk w) for n ticks, then move on.
  task automatic phase(input string tag, input logic [2:0] st, input int n, input logic w);
    logic [5:0] lp;
    lp = lamps_of(st);
    for (int i = 0; i < n; i++) begin
      check({tag, ".state"}, 32'(state), 32'(st));
      check({tag, ".main"}, 32'(main_light), 32'(lp[5:3]));
      check({tag, ".side"}, 32'(side_light), 32'(lp[2:0]));
      check({tag, ".walk"}, 32'(walk), 32'(w));
      tick();
    end
  endtask

  task automatic pulse_car();
    side_car = 1'b1;
    cyc();
    side_car = 1'b0;
  endtask

  task automatic pulse_ped();
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
  endtask

  // Release reset only while slow_clk is low so the next rise is a tick.
  task automatic release_reset();
    for (int k = 0; k < 8; k++) begin
      if (slow_clk == 1'b0) break;
      cyc();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values
    rst_n = 1'b0;
    repeat (3) cyc();
    check("rst.state", 32'(state), 32'd0);
    check("rst.main", 32'(main_light), 32'h4);
    check("rst.side", 32'(side_light), 32'h4);
    check("rst.walk", 32'(walk), 32'd0);
    check("rst.timer", 32'(dut.timer_q), 32'd0);
    check("rst.slow_q", 32'(dut.slow_q), 32'd1);
    release_reset();

    // 1: one tick all-red, then green held for 100 ticks with no request
    phase("t1.arb", 3'd0, 1, 1'b0);
    phase("t1.green", 3'd1, 100, 1'b0);

    // 2: side car after minimum green
    pulse_car();
    phase("t2.green", 3'd1, 1, 1'b0);
    phase("t2.my", 3'd2, 3, 1'b0);
    phase("t2.ara", 3'd3, 1, 1'b0);
    check("t2.car_pend", 32'(dut.car_pend_q), 32'd0);
    phase("t2.sg", 3'd4, 5, 1'b0);
    phase("t2.sy", 3'd5, 3, 1'b0);
    phase("t2.arb", 3'd0, 1, 1'b0);

    // 3: pedestrian during minimum green; walk for the whole side green
    phase("t3.green_a", 3'd1, 2, 1'b0);
    pulse_ped();
    phase("t3.green_b", 3'd1, 6, 1'b0);
    phase("t3.my", 3'd2, 3, 1'b0);
    phase("t3.ara", 3'd3, 1, 1'b0);
    phase("t3.sg", 3'd4, 5, 1'b1);
    phase("t3.sy", 3'd5, 3, 1'b0);
    phase("t3.arb", 3'd0, 1, 1'b0);

    // 4: request during side green is held for the next cycle
    pulse_car();
    phase("t4.green", 3'd1, 8, 1'b0);
    phase("t4.my", 3'd2, 3, 1'b0);
    phase("t4.ara", 3'd3, 1, 1'b0);
    phase("t4.sg_a", 3'd4, 2, 1'b0);
    pulse_car();
    phase("t4.sg_b", 3'd4, 3, 1'b0);
    phase("t4.sy", 3'd5, 3, 1'b0);
    phase("t4.arb", 3'd0, 1, 1'b0);
    phase("t4.green2", 3'd1, 8, 1'b0);
    phase("t4.my2", 3'd2, 3, 1'b0);
    phase("t4.ara2", 3'd3, 1, 1'b0);
    phase("t4.sg2", 3'd4, 5, 1'b0);
    phase("t4.sy2", 3'd5, 3, 1'b0);
    phase("t4.arb2", 3'd0, 1, 1'b0);

    // 5: slow_clk held high gives one tick; high at reset release gives none
    auto_slow = 1'b0;
    slow_clk  = 1'b0;
    repeat (2) cyc();
    check("t5.timer0", 32'(dut.timer_q), 32'd0);
    slow_clk = 1'b1;
    repeat (50) cyc();
    check("t5.timer1", 32'(dut.timer_q), 32'd1);
    check("t5.state", 32'(state), 32'd1);
    rst_n = 1'b0;
    repeat (2) cyc();
    check("t5.rst_state", 32'(state), 32'd0);
    check("t5.rst_main", 32'(main_light), 32'h4);
    rst_n = 1'b1;
    repeat (10) cyc();
    check("t5.no_tick_state", 32'(state), 32'd0);
    check("t5.no_tick_timer", 32'(dut.timer_q), 32'd0);
    slow_clk = 1'b0;
    cyc();
    slow_clk = 1'b1;
    cyc();
    check("t5.rise_state", 32'(state), 32'd1);
    phase_cur = 1;
    auto_slow = 1'b1;

    // 6: reset mid side-yellow with a pedestrian pending
    pulse_car();
    phase("t6.green", 3'd1, 8, 1'b0);
    phase("t6.my", 3'd2, 3, 1'b0);
    phase("t6.ara", 3'd3, 1, 1'b0);
    phase("t6.sg", 3'd4, 5, 1'b0);
    phase("t6.sy", 3'd5, 1, 1'b0);
    pulse_ped();
    check("t6.ped_set", 32'(dut.ped_pend_q), 32'd1);
    check("t6.mid_sy", 32'(state), 32'd5);
    rst_n = 1'b0;
    cyc();
    check("t6.rst_state", 32'(state), 32'd0);
    check("t6.rst_main", 32'(main_light), 32'h4);
    check("t6.rst_side", 32'(side_light), 32'h4);
    check("t6.rst_walk", 32'(walk), 32'd0);
    check("t6.rst_ped", 32'(dut.ped_pend_q), 32'd0);
    check("t6.rst_car", 32'(dut.car_pend_q), 32'd0);
    check("t6.rst_timer", 32'(dut.timer_q), 32'd0);
    release_reset();
    phase("t6.arb", 3'd0, 1, 1'b0);
    phase("t6.green_hold", 3'd1, 12, 1'b0);

    // Illegal state code recovers to all-red B, all-red lamps throughout
    force dut.state_q = 3'd7;
    #1;
    check("ill.state", 32'(state), 32'd7);
    check("ill.main", 32'(main_light), 32'h4);
    check("ill.side", 32'(side_light), 32'h4);
    check("ill.walk", 32'(walk), 32'd0);
    release dut.state_q;
    cyc();
    check("ill.rec_state", 32'(state), 32'd0);
    check("ill.rec_main", 32'(main_light), 32'h4);
    check("ill.rec_side", 32'(side_light), 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
